// File: rtl/instr_fetch_unit.sv
// Program counter and instruction-fetch stage for the single-cycle RV32I core.
// Fetches the word at pc over a req/ready/rvalid handshake and holds it until the
// datapath acknowledges execution. It then advances to pc+4 or the branch target,
// or traps when the target is misaligned.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013,
   // reset value of the retired-instruction counter; left at zero in the core
   parameter logic [31:0] INSTRET_INIT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pc_src,
   input  logic [31:0] imm_ext,
   input  logic        instr_ack,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        fetch_err,
   output logic [31:0] instret
);

   localparam int unsigned XLEN = 32;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_HOLD = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic [XLEN-1:0]   instr_q, instr_d;
   logic [XLEN-1:0]   instret_q, instret_d;
   logic              err_q, err_d;
   logic [XLEN-1:0]   next_pc;

   // State and datapath registers; reset abandons any in-flight fetch
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= NOP_INSTR;
         instret_q <= INSTRET_INIT;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         instret_q <= instret_d;
         err_q     <= err_d;
      end
   end

   // Next-state logic: fetch handshake, hold, pc update and misalignment trap
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      instret_d = instret_q;
      err_d     = err_q;
      next_pc   = pc_src ? (pc_q + imm_ext) : (pc_q + XLEN'(4));

      case (state_q)
         S_IDLE: state_d = S_REQ;

         S_REQ: begin
            if (imem_ready) begin
               if (imem_rvalid) begin
                  instr_d = imem_rdata;
                  state_d = S_HOLD;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end

         S_WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            if (instr_ack) begin
               instret_d = instret_q + XLEN'(1);
               instr_d   = NOP_INSTR;
               if (next_pc[1:0] != 2'b00) begin
                  err_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  pc_d    = next_pc;
                  state_d = S_REQ;
               end
            end
         end

         S_ERR: state_d = S_ERR;

         default: state_d = S_IDLE;
      endcase
   end

   // Moore decodes of registered state
   assign imem_req    = (state_q == S_REQ);
   assign instr_valid = (state_q == S_HOLD);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign fetch_err   = err_q;
   assign instret     = instret_q;
   assign pc_plus4    = pc_q + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, sequential fetch, branches,
// slow memory, address/counter wrap, reset mid-fetch and misaligned trap.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        pc_src;
   logic [31:0] imm_ext;
   logic        instr_ack;
   logic        instr_ack1;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   logic        imem_req,  imem_req1;
   logic [31:0] imem_addr, imem_addr1;
   logic        instr_valid, instr_valid1;
   logic [31:0] instr, instr1;
   logic [31:0] pc, pc1;
   logic [31:0] pc_plus4, pc_plus41;
   logic        fetch_err, fetch_err1;
   logic [31:0] instret, instret1;

   int n_checks = 0;
   int n_errors = 0;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imm_ext(imm_ext),
      .instr_ack(instr_ack), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .pc(pc), .pc_plus4(pc_plus4),
      .fetch_err(fetch_err), .instret(instret)
   );

   // second instance starting at the top of the address space with a full counter
   instr_fetch_unit #(
      .RESET_PC(32'hFFFF_FFFC),
      .INSTRET_INIT(32'hFFFF_FFFF)
   ) dut_wrap (
      .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imm_ext(imm_ext),
      .instr_ack(instr_ack1), .imem_req(imem_req1), .imem_addr(imem_addr1),
      .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid1), .instr(instr1), .pc(pc1), .pc_plus4(pc_plus41),
      .fetch_err(fetch_err1), .instret(instret1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},     32'(imem_req),    32'd0);
      check({tag, "_valid"},   32'(instr_valid), 32'd0);
      check({tag, "_instr"},   instr,            32'h0000_0013);
      check({tag, "_pc"},      pc,               32'h0);
      check({tag, "_pc4"},     pc_plus4,         32'h4);
      check({tag, "_err"},     32'(fetch_err),   32'd0);
      check({tag, "_instret"}, instret,          32'd0);
   endtask

   initial begin
      rst_n       = 1'b1;
      pc_src      = 1'b0;
      imm_ext     = 32'h0;
      instr_ack   = 1'b0;
      instr_ack1  = 1'b0;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");

      // release: request at cycle 1, held instruction at cycle 2
      rst_n = 1'b1;
      tick();
      check("c1_req",   32'(imem_req),    32'd1);
      check("c1_addr",  imem_addr,        32'h0);
      check("c1_valid", 32'(instr_valid), 32'd0);
      tick();
      check("c2_valid", 32'(instr_valid), 32'd1);
      check("c2_req",   32'(imem_req),    32'd0);
      check("c2_instr", instr,            32'h0050_0093);
      check("c2_pc",    pc,               32'h0);
      check("c2_pc4",   pc_plus4,         32'h4);
      check("w_pc",     pc1,              32'hFFFF_FFFC);
      check("w_pc4",    pc_plus41,        32'h0);
      check("w_valid",  32'(instr_valid1), 32'd1);

      // sequential run of four acks, second instance wraps on the first
      for (int k = 0; k < 4; k++) begin
         instr_ack = 1'b1;
         if (k == 0) instr_ack1 = 1'b1;
         tick();
         instr_ack  = 1'b0;
         instr_ack1 = 1'b0;
         check($sformatf("seq%0d_req", k),   32'(imem_req), 32'd1);
         check($sformatf("seq%0d_addr", k),  imem_addr,     32'(4 * (k + 1)));
         check($sformatf("seq%0d_instr", k), instr,         32'h0000_0013);
         if (k == 0) begin
            check("w_addr",    imem_addr1,      32'h0);
            check("w_req",     32'(imem_req1),  32'd1);
            check("w_instret", instret1,        32'h0);
         end
         tick();
         check($sformatf("seq%0d_valid", k), 32'(instr_valid), 32'd1);
      end
      check("seq_instret", instret, 32'd4);
      check("seq_pc",      pc,      32'h10);

      // taken backward branch from 0x10 by -8
      pc_src    = 1'b1;
      imm_ext   = 32'hFFFF_FFF8;
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      pc_src    = 1'b0;
      check("br_req",  32'(imem_req), 32'd1);
      check("br_addr", imem_addr,     32'h8);
      tick();
      check("br_pc",      pc,      32'h8);
      check("br_instret", instret, 32'd5);

      // slow memory: ack, then ready withheld three cycles
      imem_ready  = 1'b0;
      imem_rvalid = 1'b0;
      instr_ack   = 1'b1;
      tick();
      instr_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("slow_req%0d", k),  32'(imem_req), 32'd1);
         check($sformatf("slow_addr%0d", k), imem_addr,     32'hC);
         tick();
      end
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      check("slow_wait_req", 32'(imem_req), 32'd0);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("slow_nv%0d", k), 32'(instr_valid), 32'd0);
         tick();
      end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      check("slow_pre_valid", 32'(instr_valid), 32'd0);
      tick();
      imem_rvalid = 1'b0;
      check("slow_valid", 32'(instr_valid), 32'd1);
      check("slow_instr", instr,            32'hDEAD_BEEF);
      check("slow_pc",    pc,               32'hC);
      tick();
      check("slow_hold", instr, 32'hDEAD_BEEF);

      // reset pulsed while waiting for rvalid
      imem_ready = 1'b1;
      instr_ack  = 1'b1;
      tick();
      instr_ack = 1'b0;
      check("rw_addr", imem_addr, 32'h10);
      tick();
      imem_ready = 1'b0;
      check("rw_wait_req", 32'(imem_req), 32'd0);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      tick();
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      tick();
      check("stale_req",   32'(imem_req),    32'd1);
      check("stale_valid", 32'(instr_valid), 32'd0);
      tick();
      check("stale_req2",   32'(imem_req),    32'd1);
      check("stale_valid2", 32'(instr_valid), 32'd0);
      check("stale_instr",  instr,            32'h0000_0013);

      // misaligned branch target traps
      imem_ready  = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h0050_0093;
      tick();
      check("mis_pc0", pc, 32'h0);
      pc_src    = 1'b1;
      imm_ext   = 32'h10;
      instr_ack = 1'b1;
      tick();
      instr_ack = 1'b0;
      tick();
      check("mis_pc", pc, 32'h10);
      imm_ext   = 32'h6;
      instr_ack = 1'b1;
      tick();
      check("err_flag",    32'(fetch_err),   32'd1);
      check("err_req",     32'(imem_req),    32'd0);
      check("err_valid",   32'(instr_valid), 32'd0);
      check("err_instr",   instr,            32'h0000_0013);
      check("err_pc",      pc,               32'h10);
      check("err_instret", instret,          32'd2);
      tick();
      instr_ack = 1'b0;
      pc_src    = 1'b0;
      tick();
      check("err_stay_req",     32'(imem_req),  32'd0);
      check("err_stay_flag",    32'(fetch_err), 32'd1);
      check("err_stay_instret", instret,        32'd2);
      check("err_stay_pc",      pc,             32'h10);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
